vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Single-port video-RAM arbiter for the VGA text path. It shares one synchronous 80x60-cell character RAM between two requesters. The first is the display fetch, driven by the vga_sync timing outputs (p_tick, video_on, pixel_x, pixel_y). The second is a host read/write port with a req/ack handshake. Display fetch always wins. The host gets the remaining RAM slots, optionally only during blanking.

## Interface
Parameters:
- COLS, 80, text columns (cell = 8x8 pixels)
- ROWS, 60, text rows
- ADDR_W, 13, RAM address width (must cover COLS*ROWS)
- DATA_W, 8, character code width

Ports:
- clk  in  1  system clock, 100 MHz (p_tick = 1-in-4 enable)
- reset  in  1  synchronous, active-high
- p_tick  in  1  pixel enable from vga_sync
- video_on  in  1  active-area flag from vga_sync
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- host_req  in  1  host request, level, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req
- host_addr  in  ADDR_W  cell address; stable while host_req
- host_wdata  in  DATA_W  write data; stable while host_req
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  read data, valid when host_ack and read
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
- pix_data  out  DATA_W  fetched character code
- pix_valid  out  1  one-cycle pulse when pix_data updates

## Operation
- Each clock edge the arbiter issues at most one RAM op, registered onto ram_*.
- A display fetch is needed when p_tick && video_on && pixel_x[2:0]==0.
  - Fetch address: pixel_y[9:3]*COLS + pixel_x[9:3]. Computed at ADDR_W width; never exceeds COLS*ROWS-1.
- Host grant requires all of:
  - host_req=1
  - no fetch needed this cycle
  - no host read outstanding
  - host_ack not being asserted this cycle
- The "host_ack not asserted" condition guarantees at least one idle cycle between host ops.
- Read-return pipeline: 2-stage tag shift register, with tags NONE/PIX/HOST, tracks which requester owns ram_rdata.
- Out-of-range host_addr (>= COLS*ROWS):
  - The op is not issued to RAM; ram_we stays 0.
  - host_ack still pulses with normal latency.
  - For a read, host_rdata = 0.
- Arbiter states:
  - IDLE: no host op pending.
  - HOST_WR: write issued; host_ack pending.
  - HOST_RD: read in flight; wait for HOST tag at pipe end.
  - HOST_WR and HOST_RD return to IDLE on host_ack.
  - Fetches proceed in any state and never wait.
- Simultaneous fetch and host_req: the fetch is issued. The host is retried on the next free cycle, and its request must stay held.
- Reset mid-operation:
  - In-flight host op is dropped with no host_ack; the host must re-request.
  - Pipeline tags are cleared, so no stale pix_valid follows.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, host_ack=0, host_rdata=0, pix_data=0, pix_valid=0, state IDLE, tags NONE.

## Timing
- Let cycle N be the edge at which the decision is made.
- N+1: ram_addr, ram_we and ram_wdata are valid.
- N+2: ram_rdata is valid.
- End of N+2: rdata is captured.
- Fetch:
  - pix_data/pix_valid are visible in cycle N+3 (3-clock latency).
  - This is less than the 4-clock p_tick period, so no fetch overlap is possible.
- Host write: host_ack pulses in cycle N+1, together with ram_we=1.
- Host read: host_ack and host_rdata are valid in cycle N+3.
- Fetch occupies at most 1 of every 32 clocks (one per 8-pixel cell), so host bandwidth in the active area is at least 31/32 of slots.

## Configuration
- Macro: VRAM_BLANK_ONLY_EN.
- Defined: host grant additionally requires video_on=0. Host ops stall through the active area, which gives tear-free updates.
- Undefined: host uses any non-fetch cycle, as described above.

## Test plan
- Reset: hold reset 1 cycle mid-frame → all outputs 0 on the next cycle; a pending host read produces no host_ack.
- Fetch address: pixel_x=16, pixel_y=9 with p_tick=1 and video_on=1 → ram_addr=1*80+2=82 in N+1, pix_valid pulse in N+3 with pix_data = RAM[82].
- Write/read back: write 0x41 to addr 4799 → host_ack in N+1. Then read addr 4799 → host_ack in N+3 with host_rdata=0x41.
- Collision: host_req rises in the same cycle a fetch is needed → fetch issued first, host op issued on the next cycle, host_ack delayed by exactly 1 cycle.
- Out of range: write to addr 4800 → host_ack pulses, ram_we never asserts, RAM unchanged.
- VRAM_BLANK_ONLY_EN: host_req asserted at video_on=1 → no host_ack until the first cycle after video_on falls, then normal latency.

Source files
------------

// File: rtl/vga_vram_arbiter_if.sv
// Host req/ack port of the VGA text-RAM arbiter.
// The host drives the request side; the arbiter drives ack and read data.
interface vga_vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port character RAM arbiter: display fetch always wins, host gets spare slots.
// Define VRAM_BLANK_ONLY_EN to restrict host ops to blanking (video_on=0).
module vga_vram_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    vga_vram_arbiter_if.slave host,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);

    typedef enum logic [1:0] {S_IDLE, S_HOST_WR, S_HOST_RD} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_PIX, TAG_HOST} tag_t;

    state_t            state, state_next;
    tag_t              tag0, tag1;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_oor;
    logic              fetch;
    logic              grant;
    logic              oor;
    logic [ADDR_W-1:0] fetch_addr;
    logic              unused;

    assign unused          = ^pixel_y[2:0];
    assign host.host_ack   = ack_q;
    assign host.host_rdata = rdata_q;

    always_comb begin
        fetch      = p_tick && video_on && (pixel_x[2:0] == 3'd0);
        fetch_addr = ADDR_W'(pixel_y[9:3]) * ADDR_W'(COLS) + ADDR_W'(pixel_x[9:3]);
        oor        = host.host_addr >= CELLS;
`ifdef VRAM_BLANK_ONLY_EN
        grant = host.host_req && !fetch && (state == S_IDLE) && !ack_q && !video_on;
`else
        grant = host.host_req && !fetch && (state == S_IDLE) && !ack_q;
`endif
        state_next = state;
        case (state)
            S_IDLE:    if (grant) state_next = host.host_we ? S_HOST_WR : S_HOST_RD;
            S_HOST_WR: if (ack_q) state_next = S_IDLE;
            S_HOST_RD: if (tag1 == TAG_HOST) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            rd_oor    <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            tag0      <= TAG_NONE;
            tag1      <= TAG_NONE;
        end else begin
            ram_we    <= 1'b0;
            ack_q     <= 1'b0;
            pix_valid <= 1'b0;
            tag0      <= TAG_NONE;
            tag1      <= tag0;
            if (fetch) begin
                ram_addr <= fetch_addr;
                tag0     <= TAG_PIX;
            end else if (grant) begin
                // Out-of-range ops never reach the RAM but still complete.
                if (!oor) ram_addr <= host.host_addr;
                if (host.host_we) begin
                    ram_we <= !oor;
                    ack_q  <= 1'b1;
                    if (!oor) ram_wdata <= host.host_wdata;
                end else begin
                    tag0   <= TAG_HOST;
                    rd_oor <= oor;
                end
            end
            if (tag1 == TAG_PIX) begin
                pix_data  <= ram_rdata;
                pix_valid <= 1'b1;
            end
            if (tag1 == TAG_HOST) begin
                ack_q   <= 1'b1;
                rdata_q <= rd_oor ? '0 : ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural 1-cycle synchronous RAM.
// Build with VRAM_BLANK_ONLY_EN defined to exercise the blanking-only host path.
module tb_vga_vram_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick, video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       ram_we;
    logic [12:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata, pix_data;
    logic       pix_valid;
    logic [7:0] mem [0:8191];
    int         pass_cnt = 0;
    int         tot_cnt = 0;

    vga_vram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) hif ();

    vga_vram_arbiter dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .host(hif.slave),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    initial for (int i = 0; i < 8192; i++) mem[i] = pat(i);

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic host_op(input bit we, input logic [12:0] a, input logic [7:0] d,
                           input bit collide, output int lat, output logic [7:0] rd,
                           output bit saw_we, output logic [12:0] first_addr);
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = a;
        hif.host_wdata = d;
        if (collide) begin
            p_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd16; pixel_y = 10'd9;
        end
        lat = -1; rd = '0; saw_we = 1'b0; first_addr = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) begin
                first_addr = ram_addr;
                if (collide) begin p_tick = 1'b0; video_on = 1'b0; end
            end
            if (ram_we) saw_we = 1'b1;
            if (hif.host_ack) begin
                lat = i;
                rd  = hif.host_rdata;
                break;
            end
        end
        hif.host_req = 1'b0;
        step();
    endtask

    typedef struct {
        logic       pt;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       fetch;
        int         addr;
    } vec_t;

    vec_t vecs [8];
    int          lat;
    logic [7:0]  rd;
    bit          saw_we;
    logic [12:0] fa;
    bit          any;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 10'd16,  10'd9,   1'b1, 82};
        vecs[1] = '{1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 0};
        vecs[2] = '{1'b1, 1'b1, 10'd632, 10'd479, 1'b1, 4799};
        vecs[3] = '{1'b1, 1'b1, 10'd8,   10'd8,   1'b1, 81};
        vecs[4] = '{1'b1, 1'b1, 10'd320, 10'd240, 1'b1, 2440};
        vecs[5] = '{1'b1, 1'b1, 10'd17,  10'd9,   1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, 10'd16,  10'd9,   1'b0, 0};
        vecs[7] = '{1'b1, 1'b0, 10'd16,  10'd9,   1'b0, 0};

        reset = 1'b1; p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
        hif.host_req = 0; hif.host_we = 0; hif.host_addr = 0; hif.host_wdata = 0;
        step(); step();
        reset = 1'b0;
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_ack", 32'(hif.host_ack), 0);
        check("rst_rdata", 32'(hif.host_rdata), 0);
        check("rst_pix", 32'({pix_valid, pix_data}), 0);

        foreach (vecs[k]) begin
            p_tick = vecs[k].pt; video_on = vecs[k].von;
            pixel_x = vecs[k].px; pixel_y = vecs[k].py;
            step();
            if (vecs[k].fetch) check($sformatf("fetch_addr[%0d]", k), 32'(ram_addr), 32'(vecs[k].addr));
            p_tick = 1'b0; video_on = 1'b0;
            step(); step();
            check($sformatf("pix_valid[%0d]", k), 32'(pix_valid), 32'(vecs[k].fetch));
            if (vecs[k].fetch) check($sformatf("pix_data[%0d]", k), 32'(pix_data), 32'(pat(vecs[k].addr)));
            step();
        end

        host_op(1'b1, 13'd4799, 8'h41, 1'b0, lat, rd, saw_we, fa);
        check("wr_lat", 32'(lat), 1);
        check("wr_ram_we", 32'(saw_we), 1);
        check("wr_mem", 32'(mem[4799]), 32'h41);
        host_op(1'b0, 13'd4799, 8'h00, 1'b0, lat, rd, saw_we, fa);
        check("rd_lat", 32'(lat), 3);
        check("rd_data", 32'(rd), 32'h41);

        host_op(1'b1, 13'd4800, 8'h77, 1'b0, lat, rd, saw_we, fa);
        check("oor_wr_lat", 32'(lat), 1);
        check("oor_wr_no_we", 32'(saw_we), 0);
        check("oor_mem", 32'(mem[4800]), 32'(pat(4800)));
        host_op(1'b0, 13'd5000, 8'h00, 1'b0, lat, rd, saw_we, fa);
        check("oor_rd_lat", 32'(lat), 3);
        check("oor_rd_data", 32'(rd), 0);

        host_op(1'b1, 13'd100, 8'h99, 1'b1, lat, rd, saw_we, fa);
        check("col_first_addr", 32'(fa), 82);
        check("col_wr_lat", 32'(lat), 2);
        check("col_mem", 32'(mem[100]), 32'h99);
        host_op(1'b0, 13'd100, 8'h00, 1'b1, lat, rd, saw_we, fa);
        check("col_rd_lat", 32'(lat), 4);
        check("col_rd_data", 32'(rd), 32'h99);
        repeat (3) step();

        // Reset lands with a fetch and a host read both in the pipeline.
        p_tick = 1; video_on = 1; pixel_x = 10'd16; pixel_y = 10'd9;
        hif.host_req = 1; hif.host_we = 0; hif.host_addr = 13'd82;
        step();
        p_tick = 0; video_on = 0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; hif.host_req = 1'b0;
        check("mrst_ram", 32'({ram_we, ram_addr, ram_wdata}), 0);
        check("mrst_host", 32'({hif.host_ack, hif.host_rdata}), 0);
        check("mrst_pix", 32'({pix_valid, pix_data}), 0);
        any = 1'b0;
        repeat (5) begin
            step();
            if (hif.host_ack || pix_valid) any = 1'b1;
        end
        check("mrst_no_stale", 32'(any), 0);

`ifdef VRAM_BLANK_ONLY_EN
        video_on = 1'b1;
        hif.host_req = 1; hif.host_we = 1; hif.host_addr = 13'd200; hif.host_wdata = 8'h3C;
        any = 1'b0;
        repeat (6) begin
            step();
            if (hif.host_ack) any = 1'b1;
        end
        check("blank_stall", 32'(any), 0);
        video_on = 1'b0;
        step();
        check("blank_ack", 32'(hif.host_ack), 1);
        hif.host_req = 1'b0;
        step();
        check("blank_mem", 32'(mem[200]), 32'h3C);
`else
        video_on = 1'b1;
        host_op(1'b1, 13'd200, 8'h3C, 1'b0, lat, rd, saw_we, fa);
        video_on = 1'b0;
        check("active_wr_lat", 32'(lat), 1);
        check("active_mem", 32'(mem[200]), 32'h3C);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
